// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared state encoding, widths and PC fix-up helper for the fetch stage
package fetch_unit_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Addresses are numbered MSB-first: [ADDR_W-2:ADDR_W-1] are the two LSBs,
  // [0:ADDR_W-33] is the upper word cleared in 32-bit mode.
  function automatic logic [0:ADDR_W-1] fix_pc(input logic [0:ADDR_W-1] pc,
                                               input logic              is_64,
                                               input logic              align);
    logic [0:ADDR_W-1] r;
    r = pc;
    if (align) r[ADDR_W-2:ADDR_W-1] = 2'b00;
    if (!is_64) r[0:ADDR_W-33] = '0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO holding {address, instruction} entries for the decoder
module fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with req/ack memory handshake, redirect and flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                      addressWidth = ADDR_W,
  parameter int                      instrWidth   = INSTR_W,
  parameter logic [0:addressWidth-1] resetVector  = '0,
  parameter int                      queueDepth   = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    stall_i,
  input  logic                    is64Bit_i,
  input  logic                    isBranching_i,
  input  logic [0:addressWidth-1] branchPC_i,
  output logic                    memReq_o,
  output logic [0:addressWidth-1] memAddr_o,
  input  logic                    memAck_i,
  input  logic [0:instrWidth-1]   memData_i,
  output logic                    instrValid_o,
  output logic [0:instrWidth-1]   instruction_o,
  output logic [0:addressWidth-1] instructionAddress_o,
  output logic                    flush_o
);

  localparam int E_W   = addressWidth + instrWidth;
  localparam int CNT_W = $clog2(queueDepth) + 1;

  fetch_state_e            state_q;
  fetch_state_e            state_d;
  logic [0:addressWidth-1] fetch_pc_q;
  logic [0:addressWidth-1] req_addr_q;
  logic                    flush_q;
  logic                    mem_req;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [E_W-1:0]          q_wdata;
  logic [E_W-1:0]          q_rdata;
  logic                    q_full;
  logic                    q_empty;
  logic [CNT_W-1:0]        q_count;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (issue) state_d = WAIT;
      WAIT: begin
        if (memAck_i)           state_d = FETCH;
        else if (isBranching_i) state_d = DRAIN;
      end
      DRAIN:   if (memAck_i) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Only FETCH issues, so nothing is outstanding there and the live count is the reservation.
  always_comb begin
    mem_req = 1'b0;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      FETCH: issue = !isBranching_i && (q_count < CNT_W'(queueDepth));
      WAIT: begin
        mem_req = 1'b1;
        push    = memAck_i && !isBranching_i && !q_full;
      end
      DRAIN:   mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q <= resetVector;
      req_addr_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      flush_q <= isBranching_i;
      if (isBranching_i)
        fetch_pc_q <= fix_pc(branchPC_i, is64Bit_i, 1'b1);
      else if (push)
        fetch_pc_q <= fix_pc(fetch_pc_q + addressWidth'(4), is64Bit_i, 1'b0);
      if (issue)
        req_addr_q <= fetch_pc_q;
    end
  end

  assign pop     = instrValid_o && !stall_i;
  assign q_wdata = {req_addr_q, memData_i};

  fetch_queue #(
    .WIDTH (E_W),
    .DEPTH (queueDepth)
  ) u_queue (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .clear   (isBranching_i),
    .wdata   (q_wdata),
    .rdata   (q_rdata),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign memReq_o             = mem_req;
  assign memAddr_o            = mem_req ? req_addr_q : '0;
  assign flush_o              = flush_q;
  assign instrValid_o         = !q_empty;
  assign instruction_o        = q_empty ? '0 : q_rdata[instrWidth-1:0];
  assign instructionAddress_o = q_empty ? '0 : q_rdata[E_W-1:instrWidth];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        stall_i;
  logic        is64Bit_i;
  logic        isBranching_i;
  logic [0:63] branchPC_i;
  logic        memReq_o;
  logic [0:63] memAddr_o;
  logic        memAck_i;
  logic [0:31] memData_i;
  logic        instrValid_o;
  logic [0:31] instruction_o;
  logic [0:63] instructionAddress_o;
  logic        flush_o;

  int   tests = 0;
  int   failed = 0;
  logic auto_ack = 1'b0;

  fetch_unit #(
    .resetVector (64'h100)
  ) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .stall_i              (stall_i),
    .is64Bit_i            (is64Bit_i),
    .isBranching_i        (isBranching_i),
    .branchPC_i           (branchPC_i),
    .memReq_o             (memReq_o),
    .memAddr_o            (memAddr_o),
    .memAck_i             (memAck_i),
    .memData_i            (memData_i),
    .instrValid_o         (instrValid_o),
    .instruction_o        (instruction_o),
    .instructionAddress_o (instructionAddress_o),
    .flush_o              (flush_o)
  );

  initial forever #5 clock_i = ~clock_i;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  // Auto-responder: acks during the first cycle a request is visible.
  always @(negedge clock_i) begin
    if (auto_ack) begin
      if (memReq_o && !memAck_i) begin
        memAck_i  = 1'b1;
        memData_i = mem_word(memAddr_o);
      end else begin
        memAck_i = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic is64, input logic stall);
    reset_i       = 1'b1;
    auto_ack      = 1'b0;
    memAck_i      = 1'b0;
    memData_i     = '0;
    isBranching_i = 1'b0;
    branchPC_i    = '0;
    is64Bit_i     = is64;
    stall_i       = stall;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    step();
    while (!instrValid_o && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(instrValid_o), 64'd1);
  endtask

  initial begin
    int reqs;
    logic prev;

    // Reset state
    do_reset(1'b1, 1'b0);
    reset_i = 1'b1;
    step();
    check("rst_req",   64'(memReq_o), 64'd0);
    check("rst_addr",  memAddr_o, 64'd0);
    check("rst_valid", 64'(instrValid_o), 64'd0);
    check("rst_instr", 64'(instruction_o), 64'd0);
    check("rst_iaddr", instructionAddress_o, 64'd0);
    check("rst_flush", 64'(flush_o), 64'd0);

    // 1: sequential fetch with immediate acks
    do_reset(1'b1, 1'b0);
    auto_ack = 1'b1;
    step();
    check("t1_req1",  64'(memReq_o), 64'd1);
    check("t1_addr1", memAddr_o, 64'h100);
    step();
    check("t1_valid0", 64'(instrValid_o), 64'd1);
    check("t1_iaddr0", instructionAddress_o, 64'h100);
    check("t1_data0",  64'(instruction_o), 64'(mem_word(64'h100)));
    wait_valid("t1_1");
    check("t1_iaddr1", instructionAddress_o, 64'h104);
    check("t1_data1",  64'(instruction_o), 64'(mem_word(64'h104)));
    wait_valid("t1_2");
    check("t1_iaddr2", instructionAddress_o, 64'h108);
    check("t1_data2",  64'(instruction_o), 64'(mem_word(64'h108)));

    // 2: stall fills the queue, then drains
    do_reset(1'b1, 1'b1);
    auto_ack = 1'b1;
    reqs = 0;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (memReq_o && !prev) reqs++;
      prev = memReq_o;
    end
    check("t2_reqs",    64'(reqs), 64'd4);
    check("t2_req_off", 64'(memReq_o), 64'd0);
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", 64'(instrValid_o), 64'd1);
      check("t2_drain_addr",  instructionAddress_o, 64'h100 + 64'(4 * i));
      step();
    end
    check("t2_resume_addr", instructionAddress_o, 64'h110);
    check("t2_resume_data", 64'(instruction_o), 64'(mem_word(64'h110)));

    // 3: redirect while waiting, late ack is drained
    do_reset(1'b1, 1'b0);
    step();
    check("t3_req", 64'(memReq_o), 64'd1);
    isBranching_i = 1'b1;
    branchPC_i    = 64'h2003;
    step();
    isBranching_i = 1'b0;
    check("t3_flush1",   64'(flush_o), 64'd1);
    check("t3_hold_req", 64'(memReq_o), 64'd1);
    check("t3_hold_addr", memAddr_o, 64'h100);
    check("t3_empty",    64'(instrValid_o), 64'd0);
    step();
    check("t3_flush0", 64'(flush_o), 64'd0);
    step();
    memAck_i  = 1'b1;
    memData_i = 32'hDEAD;
    step();
    memAck_i = 1'b0;
    check("t3_no_dead", 64'(instrValid_o), 64'd0);
    check("t3_req_drop", 64'(memReq_o), 64'd0);
    step();
    check("t3_new_req",  64'(memReq_o), 64'd1);
    check("t3_new_addr", memAddr_o, 64'h2000);
    auto_ack = 1'b1;
    wait_valid("t3");
    check("t3_iaddr", instructionAddress_o, 64'h2000);
    check("t3_data",  64'(instruction_o), 64'(mem_word(64'h2000)));

    // 4: redirect coinciding with ack
    do_reset(1'b1, 1'b0);
    step();
    memAck_i      = 1'b1;
    memData_i     = 32'hBEEF;
    isBranching_i = 1'b1;
    branchPC_i    = 64'h3000;
    step();
    memAck_i      = 1'b0;
    isBranching_i = 1'b0;
    check("t4_flush1", 64'(flush_o), 64'd1);
    check("t4_dropped", 64'(instrValid_o), 64'd0);
    check("t4_req0",   64'(memReq_o), 64'd0);
    step();
    check("t4_flush0", 64'(flush_o), 64'd0);
    check("t4_req",    64'(memReq_o), 64'd1);
    check("t4_addr",   memAddr_o, 64'h3000);
    memAck_i  = 1'b1;
    memData_i = 32'h1234_5678;
    step();
    memAck_i = 1'b0;
    check("t4_valid", 64'(instrValid_o), 64'd1);
    check("t4_iaddr", instructionAddress_o, 64'h3000);
    check("t4_data",  64'(instruction_o), 64'h1234_5678);

    // 5: 32-bit mode wrap and upper-word masking
    do_reset(1'b0, 1'b0);
    step();
    isBranching_i = 1'b1;
    branchPC_i    = 64'hFFFF_FFFC;
    step();
    isBranching_i = 1'b0;
    memAck_i      = 1'b1;
    memData_i     = 32'h55;
    step();
    memAck_i = 1'b0;
    step();
    check("t5_addr_top", memAddr_o, 64'hFFFF_FFFC);
    memAck_i  = 1'b1;
    memData_i = 32'h6666;
    step();
    memAck_i = 1'b0;
    check("t5_iaddr", instructionAddress_o, 64'hFFFF_FFFC);
    step();
    check("t5_wrap_req",  64'(memReq_o), 64'd1);
    check("t5_wrap_addr", memAddr_o, 64'h0);
    isBranching_i = 1'b1;
    branchPC_i    = 64'h1_0000_0040;
    step();
    isBranching_i = 1'b0;
    memAck_i      = 1'b1;
    step();
    memAck_i = 1'b0;
    step();
    check("t5_mask_req",  64'(memReq_o), 64'd1);
    check("t5_mask_addr", memAddr_o, 64'h40);

    // 6: asynchronous reset mid-WAIT
    do_reset(1'b1, 1'b1);
    step();
    memAck_i  = 1'b1;
    memData_i = 32'h7777;
    step();
    memAck_i = 1'b0;
    step();
    check("t6_pre_req",   64'(memReq_o), 64'd1);
    check("t6_pre_valid", 64'(instrValid_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("t6_req",   64'(memReq_o), 64'd0);
    check("t6_addr",  memAddr_o, 64'd0);
    check("t6_valid", 64'(instrValid_o), 64'd0);
    check("t6_instr", 64'(instruction_o), 64'd0);
    check("t6_iaddr", instructionAddress_o, 64'd0);
    check("t6_flush", 64'(flush_o), 64'd0);
    step();
    step();
    stall_i  = 1'b0;
    auto_ack = 1'b1;
    reset_i  = 1'b0;
    step();
    check("t6_restart_req",  64'(memReq_o), 64'd1);
    check("t6_restart_addr", memAddr_o, 64'h100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that generates sequential fetch addresses and requests instruction words from instruction memory over a req/ack handshake. Fetched words are buffered, with their addresses, in a small queue that feeds the decoder. It consumes the branch unit's redirect (isBranching/PC) to restart fetch at a new address. On redirect it flushes queued and in-flight instructions.

Parameters:
resetVector, 0, PC loaded on reset.
addressWidth, 64, fetch/instruction address width.
instrWidth, 32, instruction word width.
queueDepth, 4, fetch queue entries; power of 2, at least 2.

Ports:
clock_i  in  1  clock.
reset_i  in  1  asynchronous active-high reset.
stall_i  in  1  decoder cannot accept this cycle.
is64Bit_i  in  1  1 = 64-bit mode, 0 = 32-bit mode (upper 32 address bits forced to 0).
isBranching_i  in  1  redirect strobe from branch unit.
branchPC_i  in  [0:addressWidth-1]  redirect target.
memReq_o  out  1  fetch request.
memAddr_o  out  [0:addressWidth-1]  fetch address.
memAck_i  in  1  memory returns data this cycle.
memData_i  in  [0:instrWidth-1]  fetched word.
instrValid_o  out  1  instruction_o is valid.
instruction_o  out  [0:instrWidth-1]  queue head word.
instructionAddress_o  out  [0:addressWidth-1]  queue head address.
flush_o  out  1  one-cycle pulse telling downstream to discard in-flight ops.

Behaviour:
- Reset (async, active-high): fetchPC=resetVector, queue empty, state=FETCH, memReq_o=0, memAddr_o=0, instrValid_o=0, instruction_o=0, instructionAddress_o=0, flush_o=0. Any outstanding request is abandoned; the memory must tolerate a dropped req.
- At most one outstanding request.
- Once memReq_o rises, memReq_o and memAddr_o hold stable until the cycle memAck_i=1. memAck_i while memReq_o=0 is ignored.
- States:
  - FETCH: raise req with memAddr_o=fetchPC when count+0 < queueDepth, then go to WAIT.
  - WAIT: on ack, push {fetchPC, memData_i}. Then fetchPC += 4, masked to [32:63] when !is64Bit_i. Next state FETCH. The next req can be raised the cycle after ack.
  - DRAIN: req is still held for a stale address. On ack, discard data, then go to FETCH at the redirected fetchPC.
- Redirect (isBranching_i=1, any state):
  - Queue cleared the same edge.
  - fetchPC = branchPC_i with bits [62:63] forced to 0, masked when !is64Bit_i.
  - flush_o=1 for the following cycle only.
  - If WAIT and no ack this cycle: go to DRAIN.
  - If ack in the same cycle: data discarded, go to FETCH.
  - A redirect during DRAIN updates fetchPC and stays in DRAIN.
- Queue:
  - instrValid_o = !empty; outputs show the head entry.
  - Pop on instrValid_o && !stall_i.
  - Push and pop in the same cycle is allowed, so count is unchanged.
  - A push never hits a full queue, because a request is only issued when count < queueDepth, counting the outstanding slot (reserve on issue).
  - Redirect takes priority over push and pop.
- Latency: after reset, first req in cycle 1. Ack in cycle N gives instrValid_o=1 in cycle N+1.
- Pointers wrap modulo queueDepth. Address increment wraps modulo 2^addressWidth, or 2^32 in 32-bit mode.

Decomposition:
Shared package holds:
- fetch state encoding (FETCH, WAIT, DRAIN);
- instrWidth and addressWidth constants;
- the alignment/32-bit mask helper.

One sub-module, fetch_queue: a synchronous FIFO with push, pop, clear, full, empty and count, and width = addressWidth + instrWidth.

Test Plan:
1. Reset with resetVector=0x100, memory acks every request the next cycle, stall_i=0: addresses 0x100, 0x104, 0x108 appear on instructionAddress_o in order with the matching memData_i.
2. stall_i=1 held, acks always given: exactly 4 requests issued, then memReq_o stays 0. Release stall_i: 4 instructions drain in 4 cycles and fetching resumes at 0x110.
3. Redirect with branchPC_i=0x2003 while WAIT, ack 3 cycles later with data 0xDEAD: flush_o pulses once, queue empties, 0xDEAD is never output, next memAddr_o=0x2000.
4. Redirect in the same cycle as ack: acked word dropped, next req goes to the branch target, flush_o pulses once.
5. is64Bit_i=0, fetchPC=0xFFFFFFFC, ack: next memAddr_o=0x00000000. Redirect to 0x1_0000_0040 in 32-bit mode gives memAddr_o=0x40.
6. Assert reset_i mid-WAIT (between clock edges): all outputs go to 0 immediately, with no clock edge needed. After release, first memAddr_o equals resetVector.
